// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding and the default frame geometry used by
// both the RX and TX stages so the two ends always agree on frame shape.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so that an idle (high) line is seen during and just
// after reset, and no false start bit is detected on release.
// Ports:
//   Clock   in   system clock
//   ClearN  in   asynchronous active-low reset
//   Rx      in   raw asynchronous serial line
//   RxSync  out  line value re-timed to Clock (2 cycle latency)
module uart_rx_sync (
    input  logic Clock,
    input  logic ClearN,
    input  logic Rx,
    output logic RxSync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= Rx;
            sync_q <= meta_q;
        end
    end

    assign RxSync = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer.
// Consumes the oversampling baud tick, validates the start bit at mid-bit,
// shifts data in LSB first, checks the stop bit and presents the byte with
// a one-cycle valid strobe. A low stop bit raises a one-cycle framing error
// and parks the receiver until the line goes idle again.
// Ports:
//   Clock         in   system clock
//   ClearN        in   asynchronous active-low reset
//   Tick          in   one-cycle enable, OVERSAMPLE pulses per bit period
//   Rx            in   asynchronous serial line, idle high
//   RxData        out  last good byte, bit0 = first received data bit
//   RxValid       out  one-cycle pulse: RxData just updated
//   FramingError  out  one-cycle pulse: stop bit sampled low
//   Busy          out  high whenever a frame is in progress or line is in break
//
// state | meaning
// IDLE  | waiting for the line to fall
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling data bits at their centre, LSB first
// STOP  | sampling the stop bit at its centre
// BREAK | stop bit was low; wait for the line to return high
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 Clock,
    input  logic                 ClearN,
    input  logic                 Tick,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    output logic                 FramingError,
    output logic                 Busy
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q, state_d;
    logic [SC_W-1:0]      sc_q, sc_d;
    logic [BC_W-1:0]      bc_q, bc_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    uart_rx_sync u_sync (
        .Clock  (Clock),
        .ClearN (ClearN),
        .Rx     (Rx),
        .RxSync (rx_s)
    );

    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            state_q <= IDLE;
            sc_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        // Everything except the synchroniser is frozen between ticks.
        if (Tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        sc_d    = '0;
                    end
                end

                START: begin
                    if (sc_q == SC_MID) begin
                        sc_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bc_d    = '0;
                        end else begin
                            // Low pulse shorter than half a bit: treat as noise.
                            state_d = IDLE;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end

                DATA: begin
                    // Counting restarted at mid start bit, so a full period
                    // later lands at the centre of each data bit.
                    if (sc_q == SC_LAST) begin
                        sc_d    = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bc_d    = bc_q + BC_W'(1);
                        if (bc_q == BC_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end

                STOP: begin
                    if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    sc_d    = '0;
                    bc_d    = '0;
                end
            endcase
        end
    end

    assign RxData       = data_q;
    assign RxValid      = valid_q;
    assign FramingError = ferr_q;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

    logic       Clock;
    logic       ClearN;
    logic       Tick;
    logic       Rx;
    logic [7:0] RxData;
    logic       RxValid;
    logic       FramingError;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    logic tick_en = 1'b1;
    int   tick_div = 0;

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    logic [7:0] data_q[$];

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .Clock        (Clock),
        .ClearN       (ClearN),
        .Tick         (Tick),
        .Rx           (Rx),
        .RxData       (RxData),
        .RxValid      (RxValid),
        .FramingError (FramingError),
        .Busy         (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Tick every 4 clocks, updated shortly after posedge so it is stable
    // at the next active edge and at the negedge where stimulus looks at it.
    initial begin
        Tick = 1'b0;
        forever begin
            @(posedge Clock);
            #2;
            if (tick_en) begin
                tick_div = (tick_div + 1) % 4;
                Tick = (tick_div == 0);
            end else begin
                Tick = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            if (RxValid) begin
                valid_cnt++;
                data_q.push_back(RxData);
            end
            if (FramingError) ferr_cnt++;
            if (RxValid && FramingError) both_cnt++;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            while (!Tick) @(negedge Clock);
        end
    endtask

    // One bit = 16 ticks. stall_bit selects a frame bit (0 = start) in whose
    // middle the tick is suppressed for 200 clocks; -1 for none.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stall_bit);
        logic [9:0] bits;
        bits = {stop_v, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            Rx = bits[i];
            if (i == stall_bit) begin
                wait_ticks(8);
                tick_en = 1'b0;
                repeat (200) @(negedge Clock);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
    endtask

    task automatic idle_bits(input int n);
        @(negedge Clock);
        Rx = 1'b1;
        wait_ticks(16 * n);
    endtask

    task automatic test_reset;
        Rx = 1'b1;
        ClearN = 1'b0;
        repeat (3) @(negedge Clock);
        checks++; if (RxData !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", RxData); end
        checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", RxValid); end
        checks++; if (FramingError !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", FramingError); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        ClearN = 1'b1;
        idle_bits(1);
    endtask

    task automatic test_frame_a5;
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        data_q.delete();
        send_frame(8'hA5, 1'b1, -1);
        idle_bits(2);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL a5_valid_count got %0d exp 1", valid_cnt - v0); end
        checks++; if (data_q.size() < 1 || data_q[0] !== 8'hA5) begin errors++; $display("FAIL a5_data got %h exp a5", RxData); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL a5_ferr_count got %0d exp 0", ferr_cnt - f0); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b exp 0", Busy); end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        @(negedge Clock);
        Rx = 1'b0;
        wait_ticks(4);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during got %b exp 1", Busy); end
        wait_ticks(1);
        idle_bits(2);
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", valid_cnt - v0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d exp 0", ferr_cnt - f0); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after got %b exp 0", Busy); end
    endtask

    task automatic test_framing;
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        data_q.delete();
        send_frame(8'h3C, 1'b0, -1);
        wait_ticks(16 * 3);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", ferr_cnt - f0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d exp 0", valid_cnt - v0); end
        checks++; if (RxData !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept got %h exp a5", RxData); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break got %b exp 1", Busy); end
        idle_bits(1);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b exp 0", Busy); end
        send_frame(8'h11, 1'b1, -1);
        idle_bits(2);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL after_break_valid got %0d exp 1", valid_cnt - v0); end
        checks++; if (data_q.size() < 1 || data_q[0] !== 8'h11) begin errors++; $display("FAIL after_break_data got %h exp 11", RxData); end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = valid_cnt;
        data_q.delete();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle_bits(2);
        checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", valid_cnt - v0); end
        checks++; if (data_q.size() < 1 || data_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h exp 00", (data_q.size() > 0) ? data_q[0] : 8'hxx); end
        checks++; if (data_q.size() < 2 || data_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h exp ff", (data_q.size() > 1) ? data_q[1] : 8'hxx); end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        data_q.delete();
        @(negedge Clock);
        Rx = 1'b0;
        wait_ticks(16);
        @(negedge Clock); Rx = 1'b1; wait_ticks(16);
        @(negedge Clock); Rx = 1'b0; wait_ticks(16);
        @(negedge Clock); Rx = 1'b1; wait_ticks(16);
        @(negedge Clock); Rx = 1'b1; wait_ticks(8);
        @(negedge Clock);
        ClearN = 1'b0;
        #1;
        checks++; if (RxData !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", RxData); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", Busy); end
        Rx = 1'b1;
        repeat (4) @(negedge Clock);
        ClearN = 1'b1;
        idle_bits(1);
        checks++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_no_pulse got v%0d f%0d exp v0 f0", valid_cnt - v0, ferr_cnt - f0); end
        send_frame(8'h5A, 1'b1, -1);
        idle_bits(2);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_valid got %0d exp 1", valid_cnt - v0); end
        checks++; if (RxData !== 8'h5A) begin errors++; $display("FAIL midrst_data_after got %h exp 5a", RxData); end
    endtask

    task automatic test_tick_stall;
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        data_q.delete();
        send_frame(8'h81, 1'b1, 4);
        idle_bits(2);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL stall_valid got %0d exp 1", valid_cnt - v0); end
        checks++; if (data_q.size() < 1 || data_q[0] !== 8'h81) begin errors++; $display("FAIL stall_data got %h exp 81", RxData); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL stall_ferr got %0d exp 0", ferr_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_tick_stall();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_and_ferr_together got %0d exp 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
